// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream-format constants for imem_loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int HDR_LEN = 2;
  localparam int CSUM_W  = 8;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian byte-to-word packer with lane counter
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  // Earlier bytes shift down so the first byte of a word ends in the low lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= 2'd0;
      shreg <= 24'd0;
    end else if (clear) begin
      lane  <= 2'd0;
      shreg <= 24'd0;
    end else if (byte_en) begin
      lane  <= lane + 2'd1;
      shreg <= {byte_in, shreg[23:8]};
    end
  end

  assign word_valid = byte_en && (lane == 2'd3);
  assign word       = {byte_in, shreg};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader streaming a length-prefixed, checksummed image into IM
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  proc_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  localparam int MAX_WORDS = 1 << (ADDR_WIDTH - 2);
  localparam int LEN_W     = 8 * HDR_LEN;

  state_t state, state_nx;

  logic [7:0]        hdr_lo;
  logic [LEN_W-1:0]  n_words;
  logic [LEN_W-1:0]  n_hdr;
  logic [CSUM_W-1:0] csum;
  logic              accept;
  logic              pay_acc;
  logic              rearm;
  logic              word_valid;
  logic [31:0]       word;

  assign in_ready = (state == HDR_LO) || (state == HDR_HI) ||
                    (state == PAYLOAD) || (state == CHECK);
  assign accept   = in_valid && in_ready;
  assign pay_acc  = accept && (state == PAYLOAD);
  assign rearm    = start && ((state == DONE) || (state == ERROR));
  assign n_hdr    = {in_data, hdr_lo};

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (rearm),
    .byte_en    (pay_acc),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HDR_LO;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      HDR_LO: begin
        if (accept) state_nx = HDR_HI;
      end
      HDR_HI: begin
        if (accept) begin
          if (32'(n_hdr) > 32'(MAX_WORDS)) state_nx = ERROR;
          else if (n_hdr == '0)            state_nx = CHECK;
          else                             state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // The final word is the one that brings the written count up to N.
        if (word_valid && ((32'(words_loaded) + 32'd1) == 32'(n_words)))
          state_nx = CHECK;
      end
      CHECK: begin
        if (accept) state_nx = (in_data == csum) ? DONE : ERROR;
      end
      DONE, ERROR: begin
        if (start) state_nx = HDR_LO;
      end
      default: state_nx = HDR_LO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_lo       <= 8'd0;
      n_words      <= '0;
      csum         <= '0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
    end else begin
      mem_we <= word_valid;
      if (rearm) begin
        words_loaded <= '0;
        csum         <= '0;
      end
      if (accept && (state == HDR_LO)) hdr_lo  <= in_data;
      if (accept && (state == HDR_HI)) n_words <= n_hdr;
      if (pay_acc) csum <= csum + in_data;
      if (word_valid) begin
        mem_addr     <= {words_loaded[ADDR_WIDTH-3:0], 2'b00};
        mem_wdata    <= word;
        words_loaded <= words_loaded + 1'b1;
      end
    end
  end

  assign done       = (state == DONE);
  assign error      = (state == ERROR);
  assign proc_reset = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader against a stream-level image model
module tb_imem_loader;

  localparam int AW        = 10;
  localparam int MAX_WORDS = 1 << (AW - 2);

  typedef logic [7:0] byte_q_t[$];

  logic          clk;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          proc_reset;
  logic          done;
  logic          error;
  logic [AW-2:0] words_loaded;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit have_last = 0;
  bit gapless = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .start        (start),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .proc_reset   (proc_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every IM write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_we: addr %h data %h with no write expected", mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("we_addr", 32'(mem_addr), e[63:32]);
        chk("we_data", mem_wdata, e[31:0]);
      end
      if (gapless && have_last) chk("we_spacing", 32'(cyc - last_cyc), 32'd4);
      last_cyc  = cyc;
      have_last = 1;
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    chk("in_ready_while_sending", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rearm_in_ready", 32'(in_ready), 32'd1);
    chk("rearm_flags", {29'd0, done, error, proc_reset}, 32'd0);
    chk("rearm_words_loaded", 32'(words_loaded), 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_flags", {29'd0, done, error, proc_reset}, 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
  endtask

  // Model: an image either overflows at the header, or writes all N words
  // and then completes iff the trailing byte equals the payload byte sum.
  task automatic run_image(input byte_q_t img, input bit gaps);
    int n;
    logic [7:0] sum;
    bit ok;
    n = {img[1], img[0]};
    gapless   = !gaps;
    have_last = 0;
    if (n > MAX_WORDS) begin
      send(img[0], gaps);
      send(img[1], gaps);
      ok = 0;
      n  = 0;
    end else begin
      sum = 8'd0;
      for (int k = 0; k < n; k++)
        exp_q.push_back({32'(4 * k),
                         img[2+4*k+3], img[2+4*k+2], img[2+4*k+1], img[2+4*k]});
      for (int i = 2; i < 2 + 4 * n; i++) sum = sum + img[i];
      ok = (img[2+4*n] == sum);
      foreach (img[i]) send(img[i], gaps);
    end
    chk("done", 32'(done), 32'(ok));
    chk("error", 32'(error), 32'(!ok));
    chk("proc_reset", 32'(proc_reset), 32'(ok));
    chk("in_ready_final", 32'(in_ready), 32'd0);
    chk("words_loaded", 32'(words_loaded), 32'(n));
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic make_random(output byte_q_t img);
    int n;
    logic [7:0] sum;
    logic [7:0] b;
    img = {};
    n = ($urandom_range(0, 5) == 0) ? MAX_WORDS + 1 + $urandom_range(0, 300)
                                    : $urandom_range(0, 6);
    img.push_back(n[7:0]);
    img.push_back(n[15:8]);
    if (n <= MAX_WORDS) begin
      sum = 8'd0;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        sum = sum + b;
        img.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
      img.push_back(sum);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t nominal;
    byte_q_t img;
    int wl_hold;

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b1;
    @(posedge clk); #1;

    nominal = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h01, 8'h01, 8'hFF, 8'hF7};
    run_image(nominal, 0);

    // Bytes offered while DONE must be refused and change nothing.
    wl_hold  = words_loaded;
    in_valid = 1'b1;
    repeat (5) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
      chk("done_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_words_hold", 32'(words_loaded), 32'(wl_hold));

    pulse_start();
    img = nominal;
    img[10] = 8'hF6;
    run_image(img, 0);

    pulse_start();
    img = '{8'h01, 8'h01};
    run_image(img, 0);

    pulse_start();
    img = '{8'h00, 8'h00, 8'h00};
    run_image(img, 0);
    pulse_start();
    img = '{8'h00, 8'h00, 8'h01};
    run_image(img, 0);

    pulse_start();
    run_image(nominal, 1);

    // Abort after five payload bytes: only the first full word is written.
    pulse_start();
    exp_q.push_back({32'd0, 32'h00500093});
    gapless = 0;
    for (int i = 0; i < 7; i++) send(nominal[i], 1);
    reset = 1'b0;
    #1;
    check_reset_values();
    chk("abort_outstanding", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_image(nominal, 1);

    // Sum of EF BE AD DE is 0x338, so the checksum byte is 0x38.
    pulse_start();
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    run_image(img, 0);

    for (int it = 0; it < 8; it++) begin
      pulse_start();
      make_random(img);
      run_image(img, it[0]);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
